// File: rtl/port_bundle_arbiter.sv
// N-channel valid/ready port bundle merged onto one registered output by a round-robin arbiter.
// Optional per-channel accept counters (dbg_clr/dbg_count) are built only with DEBUG_PORTS_EN defined.
module port_bundle_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef DEBUG_PORTS_EN
  ,
  input  logic                      dbg_clr,
  output logic [NUM_CH*COUNT_W-1:0] dbg_count
`endif
);

  localparam logic [CH_W:0] NUM_CH_L  = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] r_full;
  logic [WIDTH-1:0]  r_buf [NUM_CH];
  logic [WIDTH-1:0]  r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic              r_out_valid;
  logic [CH_W-1:0]   r_rr_ptr;

  logic              w_free;
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_grant_ch;
  logic [CH_W-1:0]   w_next_ptr;
  logic [CH_W:0]     w_idx;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_clear;

  assign in_ready  = ~r_full;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

  assign w_free   = ~r_out_valid | out_ready;
  assign w_accept = in_valid & ~r_full;

  // First full channel at or after r_rr_ptr, wrapping past the last channel.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
      if (w_idx >= NUM_CH_L) begin
        w_idx = w_idx - NUM_CH_L;
      end
      if (!w_grant_vld && r_full[w_idx[CH_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = w_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_next_ptr = (w_grant_ch == LAST_CH) ? '0 : w_grant_ch + 1'b1;
    w_clear    = '0;
    if (w_free && w_grant_vld) begin
      w_clear[w_grant_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_full <= (r_full | w_accept) & ~w_clear;
      if (w_free) begin
        r_out_valid <= w_grant_vld;
        if (w_grant_vld) begin
          r_out_data <= r_buf[w_grant_ch];
          r_out_ch   <= w_grant_ch;
          r_rr_ptr   <= w_next_ptr;
        end
      end
    end
  end

  // Holding registers need no reset: a cleared full flag makes their contents dead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_accept[i]) begin
        r_buf[i] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef DEBUG_PORTS_EN
  logic [COUNT_W-1:0] r_dbg_cnt [NUM_CH];

  // Clear has priority over a coincident accept.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n || dbg_clr) begin
        r_dbg_cnt[i] <= '0;
      end else if (w_accept[i]) begin
        r_dbg_cnt[i] <= r_dbg_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    dbg_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dbg_count[i*COUNT_W +: COUNT_W] = r_dbg_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_port_bundle_arbiter.sv
// Directed, table-driven bench for port_bundle_arbiter (NUM_CH=4, WIDTH=8).
// Debug-counter checks are compiled in only when DEBUG_PORTS_EN is defined.
module tb_port_bundle_arbiter;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 8;
  localparam int COUNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef DEBUG_PORTS_EN
  logic        dbg_clr;
  logic [31:0] dbg_count;
`endif

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic        rstN;
    logic [3:0]  inValid;
    logic [31:0] inData;
    logic        outReady;
    logic        expValid;
    logic        chkData;
    logic [7:0]  expData;
    logic [1:0]  expCh;
    logic [3:0]  expReady;
  } vec_t;

  vec_t vecs [28];

  always #5 clk = ~clk;

  port_bundle_arbiter #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEBUG_PORTS_EN
    ,
    .dbg_clr  (dbg_clr),
    .dbg_count(dbg_count)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic rstN, input logic [3:0] v, input logic [31:0] d, input logic rdy);
    rst_n     = rstN;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = 32'h0;
    out_ready = 1'b0;
`ifdef DEBUG_PORTS_EN
    dbg_clr   = 1'b0;
`endif

    // Round robin with ch0 refill, backpressure, pointer wrap, reset mid-transfer
    vecs[0]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h10, 2'd0, 4'b0001};
    vecs[2]  = '{1'b1, 4'b0001, 32'h00000020, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1, 4'b0010};
    vecs[3]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h12, 2'd2, 4'b0110};
    vecs[4]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h13, 2'd3, 4'b1110};
    vecs[5]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h20, 2'd0, 4'b1111};
    vecs[6]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111};
    vecs[7]  = '{1'b1, 4'b1010, 32'h66005500, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0101};
    vecs[8]  = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1, 4'b0111};
    vecs[9]  = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1, 4'b0111};
    vecs[10] = '{1'b1, 4'b0010, 32'h00007700, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1, 4'b0101};
    vecs[11] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h66, 2'd3, 4'b1101};
    vecs[12] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h77, 2'd1, 4'b1111};
    vecs[13] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111};
    vecs[14] = '{1'b1, 4'b1000, 32'h33000000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0111};
    vecs[15] = '{1'b1, 4'b0010, 32'h00003100, 1'b1, 1'b1, 1'b1, 8'h33, 2'd3, 4'b1101};
    vecs[16] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h31, 2'd1, 4'b1111};
    vecs[17] = '{1'b1, 4'b0101, 32'h00420040, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1010};
    vecs[18] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h42, 2'd2, 4'b1110};
    vecs[19] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h40, 2'd0, 4'b1111};
    vecs[20] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111};
    vecs[21] = '{1'b1, 4'b1111, 32'h83828180, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};
    vecs[22] = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b1, 8'h81, 2'd1, 4'b0010};
    vecs[23] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'b1111};
    vecs[24] = '{1'b1, 4'b1010, 32'h93009100, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0101};
    vecs[25] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h91, 2'd1, 4'b0111};
    vecs[26] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b1, 8'h93, 2'd3, 4'b1111};
    vecs[27] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111};

    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
    checkOutput("reset.outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.inReady",  {28'd0, in_ready},  32'hF);
    checkOutput("reset.outData",  {24'd0, out_data},  32'h0);
    checkOutput("reset.outCh",    {30'd0, out_ch},    32'h0);

    // Single word on ch2: buffered for one cycle, then granted
    applyStimulus(1'b1, 4'b0100, 32'h00A50000, 1'b1);
    checkOutput("single.inReadyAfterAccept", {28'd0, in_ready},  32'hB);
    checkOutput("single.outValidEarly",      {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
    checkOutput("single.outValid", {31'd0, out_valid}, 32'd1);
    checkOutput("single.outData",  {24'd0, out_data},  32'hA5);
    checkOutput("single.outCh",    {30'd0, out_ch},    32'd2);
    checkOutput("single.inReady",  {28'd0, in_ready},  32'hF);
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
    checkOutput("single.drained", {31'd0, out_valid}, 32'd0);

    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
      checkOutput($sformatf("vec%0d.outValid", i), {31'd0, out_valid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d.inReady", i),  {28'd0, in_ready},  {28'd0, vecs[i].expReady});
      if (vecs[i].chkData) begin
        checkOutput($sformatf("vec%0d.outData", i), {24'd0, out_data}, {24'd0, vecs[i].expData});
        checkOutput($sformatf("vec%0d.outCh", i),   {30'd0, out_ch},   {30'd0, vecs[i].expCh});
      end
    end

`ifdef DEBUG_PORTS_EN
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);
    checkOutput("dbg.reset", dbg_count, 32'h0);
    // ch0 held valid: accepts land on every other edge, 257 accepts in 513 edges
    for (int n = 0; n < 513; n++) begin
      applyStimulus(1'b1, 4'b0001, 32'h000000AB, 1'b1);
    end
    checkOutput("dbg.wrapCount", dbg_count, 32'h00000001);
    checkOutput("dbg.ch0Full",   {28'd0, in_ready}, 32'hE);
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
    dbg_clr = 1'b1;
    applyStimulus(1'b1, 4'b0001, 32'h000000CD, 1'b1);
    dbg_clr = 1'b0;
    checkOutput("dbg.clrWithAccept", dbg_count, 32'h0);
    checkOutput("dbg.acceptTaken",   {28'd0, in_ready}, 32'hE);
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
    applyStimulus(1'b1, 4'b0001, 32'h000000EF, 1'b1);
    checkOutput("dbg.countAfterClr", dbg_count, 32'h00000001);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
